// File: rtl/mcu_pkg.sv
// Shared MCU constants and the sequencer state type, imported by the sequencer,
// the construction mux and any later MCU-stage blocks.
package mcu_pkg;

    localparam int NUM_MCU = 28;
    localparam int SEL_W   = 11;
    localparam int ROWS    = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mcu_seq_state_t;

endpackage

// File: rtl/mcu_seq_perf.sv
// Saturating stall-cycle counter for the MCU sequencer; only instantiated when
// MCU_SEQ_PERF_EN is defined.
module mcu_seq_perf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        enable,
    input  logic        stall,
    output logic [31:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && stall && (count != 32'hFFFF_FFFF)) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/mcu_sequencer.sv
// Walks the MCU mux select through every buffered MCU and streams 8 rows per MCU
// under valid/ready. Optional stall counter output when MCU_SEQ_PERF_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; counters at 0, out_valid low
// RUN   | presenting one row beat per cycle until the last row of the last MCU
module mcu_sequencer
    import mcu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             out_ready,
    output logic [SEL_W-1:0] sel,
    output logic [2:0]       row_idx,
    output logic             out_valid,
    output logic             mcu_first,
    output logic             mcu_last,
    output logic             frame_last,
    output logic             busy,
    output logic             done
`ifdef MCU_SEQ_PERF_EN
    ,
    output logic [31:0]      stall_cycles
`endif
);

    localparam logic [2:0]       ROW_LAST = 3'(ROWS - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_MCU - 1);

    mcu_seq_state_t   state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [2:0]       row_q, row_d;
    logic             done_q, done_d;
    logic             hs;
    logic             start_acc;

    assign busy      = (state_q == RUN);
    assign out_valid = busy;
    assign hs        = out_valid & out_ready;
    assign start_acc = (state_q == IDLE) & start & ~abort;

    assign sel        = sel_q;
    assign row_idx    = row_q;
    assign done       = done_q;
    assign mcu_first  = busy & (row_q == 3'd0);
    assign mcu_last   = busy & (row_q == ROW_LAST);
    assign frame_last = mcu_last & (sel_q == SEL_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            row_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            row_q   <= row_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        row_d   = row_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_acc) begin
                    state_d = RUN;
                    sel_d   = '0;
                    row_d   = '0;
                end
            end
            RUN: begin
                // abort wins over a handshake in the same cycle and never pulses done
                if (abort) begin
                    state_d = IDLE;
                    sel_d   = '0;
                    row_d   = '0;
                end else if (hs) begin
                    if (row_q == ROW_LAST) begin
                        row_d = '0;
                        if (sel_q == SEL_LAST) begin
                            state_d = IDLE;
                            sel_d   = '0;
                            done_d  = 1'b1;
                        end else begin
                            sel_d = sel_q + SEL_W'(1);
                        end
                    end else begin
                        row_d = row_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = '0;
                row_d   = '0;
            end
        endcase
    end

`ifdef MCU_SEQ_PERF_EN
    mcu_seq_perf u_perf (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (start_acc),
        .enable (busy),
        .stall  (out_valid & ~out_ready),
        .count  (stall_cycles)
    );
`endif

endmodule
